// File: rtl/alu_pkg.sv
// Operation codes and legality decode shared by the bus ALU and the microcoded
// control unit, so both sides agree on one encoding table.
package alu_pkg;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_LOAD_A  = 5'b00000;

    localparam alu_op_t ALU_ADD     = 5'b10000;
    localparam alu_op_t ALU_SUB     = 5'b11000;
    localparam alu_op_t ALU_SLL     = 5'b10001;
    localparam alu_op_t ALU_SRL     = 5'b10101;
    localparam alu_op_t ALU_SRA     = 5'b11101;
    localparam alu_op_t ALU_SLT     = 5'b10010;
    localparam alu_op_t ALU_SLTU    = 5'b10011;
    localparam alu_op_t ALU_XOR     = 5'b10100;
    localparam alu_op_t ALU_OR      = 5'b10110;
    localparam alu_op_t ALU_AND     = 5'b10111;

    localparam alu_op_t ALU_CMP_EQ  = 5'b01000;
    localparam alu_op_t ALU_CMP_NE  = 5'b01001;
    localparam alu_op_t ALU_CMP_LT  = 5'b01100;
    localparam alu_op_t ALU_CMP_GE  = 5'b01101;
    localparam alu_op_t ALU_CMP_LTU = 5'b01110;
    localparam alu_op_t ALU_CMP_GEU = 5'b01111;

    function automatic logic is_legal_op(input alu_op_t op);
        logic legal;
        case (op)
            ALU_LOAD_A,
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
            ALU_CMP_EQ, ALU_CMP_NE, ALU_CMP_LT, ALU_CMP_GE,
            ALU_CMP_LTU, ALU_CMP_GEU: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result = f(op, x, y), x from the bus,
// y from the latched operand A. Also reports whether op is a legal code.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t          op_i,
    input  logic [XLEN-1:0]  x_i,
    input  logic [XLEN-1:0]  y_i,
    output logic [XLEN-1:0]  result_o,
    output logic             legal_o
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = y_i[4:0];
    assign lt_s  = $signed(x_i) < $signed(y_i);
    assign lt_u  = x_i < y_i;
    assign eq    = x_i == y_i;

    always_comb begin
        result_o = '0;
        legal_o  = is_legal_op(op_i);
        case (op_i)
            ALU_ADD:     result_o = x_i + y_i;
            ALU_SUB:     result_o = x_i - y_i;
            ALU_SLL:     result_o = x_i << shamt;
            ALU_SRL:     result_o = x_i >> shamt;
            ALU_SRA:     result_o = $unsigned($signed(x_i) >>> shamt);
            ALU_SLT:     result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:    result_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:     result_o = x_i ^ y_i;
            ALU_OR:      result_o = x_i | y_i;
            ALU_AND:     result_o = x_i & y_i;
            ALU_CMP_EQ:  result_o = {{(XLEN-1){1'b0}}, eq};
            ALU_CMP_NE:  result_o = {{(XLEN-1){1'b0}}, ~eq};
            ALU_CMP_LT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_CMP_GE:  result_o = {{(XLEN-1){1'b0}}, ~lt_s};
            ALU_CMP_LTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_CMP_GEU: result_o = {{(XLEN-1){1'b0}}, ~lt_u};
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/bus_alu.sv
// Bus-attached ALU: latches operand A from the shared bus, computes f(bus, A)
// into a result register, and drives that result back onto the bus on request.
module bus_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [XLEN-1:0]  bus,
    input  logic             alu_wr,
    input  logic             alu_rd,
    input  alu_op_t          alu_op,
    output logic             alu_err
);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_d;
    logic            err_q;
    logic            err_d;

    logic [XLEN-1:0] core_result;
    logic            core_legal;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .op_i     (alu_op),
        .x_i      (bus),
        .y_i      (a_q),
        .result_o (core_result),
        .legal_o  (core_legal)
    );

    // Released while in reset so the bus is free the instant rst rises.
    assign bus     = (alu_rd && !rst) ? result_q : 'z;
    assign alu_err = err_q;

    // A write while reading would capture our own output: flag it, capture nothing.
    always_comb begin
        a_d      = a_q;
        result_d = result_q;
        err_d    = err_q;
        if (alu_wr) begin
            if (alu_rd || !core_legal) begin
                err_d = 1'b1;
            end else if (alu_op == ALU_LOAD_A) begin
                a_d = bus;
            end else begin
                result_d = core_result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule
